// File: rtl/datamem_pkg.sv
// Shared types and constants for the wait-stated data memory.
// Contents:
//   dmem_state_t  - access FSM states (IDLE, WAIT, RESP)
//   XFER_*        - encodings of the xfer_size request field
package datamem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam logic [2:0] XFER_BYTE = 3'd1;
    localparam logic [2:0] XFER_HALF = 3'd2;
    localparam logic [2:0] XFER_WORD = 3'd4;

endpackage

// File: rtl/datamem_ws_load_fmt.sv
// Load result formatter: narrows the raw little-endian word to the access
// size and applies sign or zero extension.
// Ports:
//   raw_word  in  32  bytes sampled from storage, lowest address in [7:0]
//   xfer_size in  3   access size (byte / half / word)
//   sign_ext  in  1   1 = sign-extend sub-word loads, 0 = zero-extend
//   read_data out 32  formatted load value
module dmem_load_fmt
    import datamem_pkg::*;
(
    input  logic [31:0] raw_word,
    input  logic [2:0]  xfer_size,
    input  logic        sign_ext,
    output logic [31:0] read_data
);

    logic byte_fill;
    logic half_fill;

    assign byte_fill = sign_ext & raw_word[7];
    assign half_fill = sign_ext & raw_word[15];

    always_comb begin
        read_data = 32'd0;
        case (xfer_size)
            XFER_BYTE: read_data = {{24{byte_fill}}, raw_word[7:0]};
            XFER_HALF: read_data = {{16{half_fill}}, raw_word[15:0]};
            XFER_WORD: read_data = raw_word;
            default:   read_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/datamem_ws.sv
// Byte-addressed data memory with a fixed number of wait states per access.
// A request is taken in IDLE, stalls WAIT_STATES cycles, then completes with
// a one-cycle resp_valid pulse in RESP. Misaligned, oversized, out-of-range
// or illegal-size requests complete with err=1 and never touch storage.
// Ports:
//   clk          in  1   clock, rising edge
//   reset        in  1   asynchronous active-high reset (control only)
//   address      in  32  byte address
//   write_enable in  1   write request (wins over read_enable)
//   read_enable  in  1   read request
//   write_data   in  32  store data, little-endian, low bytes for sub-word
//   xfer_size    in  3   1 = byte, 2 = half, 4 = word
//   sign_ext     in  1   sign-extend sub-word loads
//   read_data    out 32  load result, 0 outside RESP
//   MemRdy       out 1   idle, request accepted this cycle
//   resp_valid   out 1   completion pulse
//   err          out 1   completed access faulted
module datamem_ws
    import datamem_pkg::*;
#(
    parameter int DEPTH_BYTES = 64,
    parameter int WAIT_STATES = 2
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        write_enable,
    input  logic        read_enable,
    input  logic [31:0] write_data,
    input  logic [2:0]  xfer_size,
    input  logic        sign_ext,
    output logic [31:0] read_data,
    output logic        MemRdy,
    output logic        resp_valid,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    dmem_state_t   state;
    logic [3:0]    wait_cnt;

    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [2:0]    req_size;
    logic          req_sext;
    logic          req_write;
    logic          req_fault;

    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic [2:0]    sel_size;
    logic          sel_write;
    logic          sel_fault;

    logic          accept;
    logic          enter_resp;
    logic [AW-1:0] base;
    logic [31:0]   raw_word;
    logic [31:0]   fmt_data;

    logic [7:0]    mem [DEPTH_BYTES];

    // Range check uses 33-bit arithmetic so addresses near 2^32 cannot wrap
    // back into the storage window.
    function automatic logic calc_fault(input logic [31:0] addr, input logic [2:0] size);
        logic [32:0] last;
        logic        bad_shape;
        last = {1'b0, addr} + {30'd0, size} - 33'd1;
        case (size)
            XFER_BYTE: bad_shape = 1'b0;
            XFER_HALF: bad_shape = addr[0];
            XFER_WORD: bad_shape = |addr[1:0];
            default:   bad_shape = 1'b1;
        endcase
        calc_fault = bad_shape || (last >= 33'(DEPTH_BYTES));
    endfunction

    assign accept = (state == IDLE) && (write_enable || read_enable);

    // With zero wait states the commit edge is the accept edge, so the
    // request has to come straight from the ports rather than the latches.
    always_comb begin
        if (state == IDLE) begin
            sel_addr  = address;
            sel_wdata = write_data;
            sel_size  = xfer_size;
            sel_write = write_enable;
        end else begin
            sel_addr  = req_addr;
            sel_wdata = req_wdata;
            sel_size  = req_size;
            sel_write = req_write;
        end
    end

    assign sel_fault  = calc_fault(sel_addr, sel_size);
    assign enter_resp = !reset &&
                        ((accept && (WAIT_STATES == 0)) || ((state == WAIT) && (wait_cnt == 4'd0)));
    assign base       = sel_addr[AW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= (WAIT_STATES > 0) ? WAIT : RESP;
                        wait_cnt <= CNT_INIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            req_addr  <= address;
            req_wdata <= write_data;
            req_size  <= xfer_size;
            req_sext  <= sign_ext;
            req_write <= write_enable;
            req_fault <= calc_fault(address, xfer_size);
        end
    end

    // Aligned legal accesses never cross the end of storage, so the byte
    // offsets below stay in range; for narrow reads the extra bytes are
    // discarded by the formatter.
    always_ff @(posedge clk) begin
        if (enter_resp && sel_write && !sel_fault) begin
            mem[base] <= sel_wdata[7:0];
            if (sel_size != XFER_BYTE) begin
                mem[base + AW'(1)] <= sel_wdata[15:8];
            end
            if (sel_size == XFER_WORD) begin
                mem[base + AW'(2)] <= sel_wdata[23:16];
                mem[base + AW'(3)] <= sel_wdata[31:24];
            end
        end
        if (enter_resp) begin
            raw_word <= {mem[base + AW'(3)], mem[base + AW'(2)], mem[base + AW'(1)], mem[base]};
        end
    end

    dmem_load_fmt u_load_fmt (
        .raw_word  (raw_word),
        .xfer_size (req_size),
        .sign_ext  (req_sext),
        .read_data (fmt_data)
    );

    assign MemRdy     = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign err        = (state == RESP) && req_fault;
    assign read_data  = ((state == RESP) && !req_fault && !req_write) ? fmt_data : 32'd0;

endmodule

// File: tb/tb_datamem_ws.sv
// Scoreboard bench for datamem_ws: directed known-answer requests, an
// abort-by-reset case and randomized traffic against a byte-array model,
// plus a zero-wait-state instance for the back-to-back throughput case.
module tb_datamem_ws;

    localparam int DEPTH = 64;
    localparam int WS    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address = 32'd0;
    logic        write_enable = 1'b0;
    logic        read_enable = 1'b0;
    logic [31:0] write_data = 32'd0;
    logic [2:0]  xfer_size = 3'd4;
    logic        sign_ext = 1'b0;
    logic [31:0] read_data;
    logic        MemRdy;
    logic        resp_valid;
    logic        err;

    logic [31:0] d0_addr = 32'd0;
    logic        d0_we = 1'b0;
    logic        d0_re = 1'b0;
    logic [31:0] d0_wd = 32'd0;
    logic [2:0]  d0_size = 3'd4;
    logic [31:0] d0_rdata;
    logic        d0_rdy;
    logic        d0_rv;
    logic        d0_err;

    always #5 clk = ~clk;

    datamem_ws #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(WS)) u_dut (
        .clk(clk), .reset(reset), .address(address), .write_enable(write_enable),
        .read_enable(read_enable), .write_data(write_data), .xfer_size(xfer_size),
        .sign_ext(sign_ext), .read_data(read_data), .MemRdy(MemRdy),
        .resp_valid(resp_valid), .err(err)
    );

    datamem_ws #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(reset), .address(d0_addr), .write_enable(d0_we),
        .read_enable(d0_re), .write_data(d0_wd), .xfer_size(d0_size),
        .sign_ext(1'b0), .read_data(d0_rdata), .MemRdy(d0_rdy),
        .resp_valid(d0_rv), .err(d0_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        chk_data;
        logic        exp_err;
        logic [31:0] exp_data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] ref_mem [DEPTH];
    logic       mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference: a flat byte array with the access rules applied directly.
    function automatic exp_t model(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                   input logic [2:0] sz, input logic sx);
        exp_t        e;
        longint      last;
        bit          f;
        logic [31:0] v;
        int          n;
        n    = int'(sz);
        last = longint'(a) + longint'(n) - 1;
        f = !(n == 1 || n == 2 || n == 4) || (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00) ||
            (last >= longint'(DEPTH));
        e.exp_err  = f;
        e.chk_data = f || !we;
        e.exp_data = 32'd0;
        if (!f) begin
            if (we) begin
                for (int k = 0; k < n; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
            end else begin
                v = 32'd0;
                for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[int'(a) + k];
                if (sx && n == 1) v = {{24{v[7]}}, v[7:0]};
                if (sx && n == 2) v = {{16{v[15]}}, v[15:0]};
                e.exp_data = v;
            end
        end
        return e;
    endfunction

    // Monitor: pops one expectation per response pulse.
    always @(negedge clk) begin
        if (mon_en) begin
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_err", {31'd0, err}, {31'd0, e.exp_err});
                    if (e.chk_data) check("resp_rdata", read_data, e.exp_data);
                end
            end else begin
                check("idle_rdata", read_data, 32'd0);
                check("idle_err", {31'd0, err}, 32'd0);
            end
        end
    end

    // Call at a negedge; returns at the negedge of the RESP cycle.
    task automatic do_req(input logic we, input logic re, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] sz, input logic sx);
        int c;
        c = 0;
        while (!MemRdy && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (!MemRdy) check("memrdy_timeout", {31'd0, MemRdy}, 32'd1);
        write_enable = we; read_enable = re; address = a;
        write_data = wd; xfer_size = sz; sign_ext = sx;
        sb.push_back(model(we, a, wd, sz, sx));
        @(posedge clk);
        #1;
        write_enable = 1'b0; read_enable = 1'b0;
        address = $urandom; write_data = $urandom; xfer_size = 3'($urandom); sign_ext = 1'($urandom);
        for (int i = 1; i <= WS + 1; i++) begin
            @(negedge clk);
            check("memrdy_busy", {31'd0, MemRdy}, 32'd0);
            check("resp_timing", {31'd0, resp_valid}, {31'd0, (i == WS + 1)});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  sizes [8];
        logic [31:0] a;
        logic [2:0]  sz;
        int          kind;
        int          c;

        sizes[0] = 3'd1; sizes[1] = 3'd2; sizes[2] = 3'd4; sizes[3] = 3'd1;
        sizes[4] = 3'd2; sizes[5] = 3'd4; sizes[6] = 3'd3; sizes[7] = 3'd0;

        #12;
        check("rst_memrdy", {31'd0, MemRdy}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", read_data, 32'd0);

        @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < DEPTH / 4; i++) do_req(1'b1, 1'b0, 32'(4 * i), $urandom, 3'd4, 1'b0);

        do_req(1'b1, 1'b0, 32'h8, 32'hDEADBEEF, 3'd4, 1'b0);
        sb.push_back('{1'b1, 1'b0, 32'hDEADBEEF});
        do_req(1'b0, 1'b1, 32'h8, 32'h0, 3'd4, 1'b0);
        void'(sb.pop_back());
        sb.push_back('{1'b1, 1'b0, 32'hFFFFFFDE});
        do_req(1'b0, 1'b1, 32'hB, 32'h0, 3'd1, 1'b1);
        void'(sb.pop_back());
        do_req(1'b0, 1'b1, 32'hB, 32'h0, 3'd1, 1'b0);
        do_req(1'b0, 1'b1, 32'hA, 32'h0, 3'd2, 1'b1);
        do_req(1'b1, 1'b0, 32'h9, 32'h1234, 3'd2, 1'b0);
        do_req(1'b0, 1'b1, 32'h8, 32'h0, 3'd4, 1'b0);
        do_req(1'b0, 1'b1, 32'h40, 32'h0, 3'd4, 1'b0);
        do_req(1'b1, 1'b1, 32'h3, 32'hA5, 3'd1, 1'b0);
        do_req(1'b0, 1'b1, 32'h3, 32'h0, 3'd1, 1'b0);

        // Write aborted by reset while stalled.
        @(negedge clk);
        write_enable = 1'b1; address = 32'h4; write_data = 32'h11111111; xfer_size = 3'd4;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_memrdy", {31'd0, MemRdy}, 32'd1);
        check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("abort_rdata", read_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        do_req(1'b0, 1'b1, 32'h4, 32'h0, 3'd4, 1'b0);

        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 2);
            sz   = sizes[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            else                           a = 32'($urandom_range(0, DEPTH + 7));
            do_req(kind != 1, kind != 0, a, $urandom, sz, 1'($urandom));
        end

        c = 0;
        while (sb.size() != 0 && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("sb_drained", 32'(sb.size()), 32'd0);
        mon_en = 1'b0;

        // Zero wait states: held write request, accepted every other cycle.
        @(negedge clk);
        check("d0_idle_rdy", {31'd0, d0_rdy}, 32'd1);
        d0_we = 1'b1; d0_addr = 32'h10; d0_size = 3'd4;
        for (int i = 0; i < 4; i++) begin
            d0_wd = 32'hC0DE0000 + 32'(i);
            @(negedge clk);
            check("d0_rdy_toggle", {31'd0, d0_rdy}, 32'(i % 2));
            check("d0_resp_toggle", {31'd0, d0_rv}, 32'((i + 1) % 2));
        end
        d0_we = 1'b0; d0_re = 1'b1;
        @(negedge clk);
        d0_re = 1'b0;
        check("d0_read_valid", {31'd0, d0_rv}, 32'd1);
        check("d0_read_err", {31'd0, d0_err}, 32'd0);
        check("d0_read_data", d0_rdata, 32'hC0DE0002);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
